// File: rtl/json_pkt_hdr_strip_pkg.sv
// Shared stream types for the JSON packet front end: beat layout, FSM states
// and a KEEP popcount helper.
package json_stream_pkg;

  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_PAY  = 2'd1,
    S_DROP = 2'd2
  } state_e;

  function automatic logic [3:0] popcount8(input logic [KEEP_W-1:0] k);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < KEEP_W; i++) begin
      n = n + {3'd0, k[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/json_pkt_hdr_strip_if.sv
// 64-bit DATA/KEEP/LAST/VALID/READY stream bundle; master drives the beat,
// slave drives READY.
interface json_pkt_hdr_strip_if;
  import json_stream_pkg::*;

  logic [DATA_W-1:0] DATA;
  logic [KEEP_W-1:0] KEEP;
  logic              LAST;
  logic              VALID;
  logic              READY;

  modport master (output DATA, KEEP, LAST, VALID, input READY);
  modport slave  (input DATA, KEEP, LAST, VALID, output READY);

endinterface

// File: rtl/json_pkt_hdr_strip_skid.sv
// stream_skid_buf: 2-entry registered handshake buffer (output register plus
// one skid entry) giving full throughput with a registered READY.
module stream_skid_buf
  import json_stream_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  beat_t in_beat,
  input  logic  in_valid,
  output logic  in_ready,
  output beat_t out_beat,
  output logic  out_valid,
  input  logic  out_ready
);

  beat_t out_q, out_d, skid_q, skid_d;
  logic  out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic  in_acc;

  assign in_ready  = ~skid_vld_q;
  assign in_acc    = in_valid & ~skid_vld_q;
  assign out_beat  = out_q;
  assign out_valid = out_vld_q;

  // Next-state: refill the output register from skid first, then from input
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!out_vld_q || out_ready) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (in_acc) begin
        out_d     = in_beat;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else begin
      if (in_acc) begin
        skid_d     = in_beat;
        skid_vld_d = 1'b1;
      end else begin
        skid_vld_d = skid_vld_q;
      end
    end
  end

  // Buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

endmodule

// File: rtl/json_pkt_hdr_strip.sv
// Strips a HDR_BEATS-beat header into a sideband word and forwards the payload,
// truncating at MAX_PAY_BEATS. JSON_PKT_HDR_STRIP_STATS_EN adds packet/byte counters.
module json_pkt_hdr_strip
  import json_stream_pkg::*;
#(
  parameter int HDR_BEATS     = 1,
  parameter int MAX_PAY_BEATS = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  json_pkt_hdr_strip_if.slave         stream_in,
  json_pkt_hdr_strip_if.master        stream_out,
  output logic [DATA_W*HDR_BEATS-1:0] hdr_DATA,
  output logic                        hdr_VALID,
  output logic                        err_runt,
  output logic                        err_trunc
`ifdef JSON_PKT_HDR_STRIP_STATS_EN
  ,
  output logic [31:0]                 stat_pkt_cnt,
  output logic [31:0]                 stat_byte_cnt
`endif
);

  localparam logic [15:0] HDR_LAST_IDX = 16'(HDR_BEATS - 1);
  localparam logic [15:0] PAY_LAST_IDX = 16'(MAX_PAY_BEATS - 1);

  state_e                      state_q, state_d;
  logic [15:0]                 cnt_q, cnt_d;
  logic [DATA_W*HDR_BEATS-1:0] hdr_q, hdr_d;
  logic                        hdr_vld_q, hdr_vld_d;
  logic                        runt_q, runt_d;
  logic                        trunc_q, trunc_d;
  logic                        in_rdy, in_acc, skid_rdy, pay_vld, out_vld;
  beat_t                       pay_beat, out_beat;

  // READY is forced low throughout reset regardless of FSM state
  assign in_rdy = ~rst & ((state_q != S_PAY) | skid_rdy);
  assign in_acc = stream_in.VALID & in_rdy;
  assign stream_in.READY = in_rdy;

  // FSM, beat counter and header capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hdr_d     = hdr_q;
    hdr_vld_d = 1'b0;
    runt_d    = 1'b0;
    trunc_d   = 1'b0;
    pay_vld   = 1'b0;
    pay_beat  = '{data: stream_in.DATA, keep: stream_in.KEEP, last: stream_in.LAST};
    case (state_q)
      S_HDR: begin
        if (in_acc) begin
          for (int i = 0; i < HDR_BEATS; i++) begin
            if (cnt_q == 16'(i)) hdr_d[i*DATA_W +: DATA_W] = stream_in.DATA;
            else                 hdr_d[i*DATA_W +: DATA_W] = hdr_q[i*DATA_W +: DATA_W];
          end
          if (cnt_q == HDR_LAST_IDX) begin
            hdr_vld_d = 1'b1;
            cnt_d     = 16'd0;
            state_d   = stream_in.LAST ? S_HDR : S_PAY;
          end else if (stream_in.LAST) begin
            runt_d = 1'b1;
            cnt_d  = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_PAY: begin
        pay_vld = in_acc;
        if (in_acc) begin
          if (stream_in.LAST) begin
            state_d = S_HDR;
            cnt_d   = 16'd0;
          end else if (cnt_q == PAY_LAST_IDX) begin
            // Truncated packet still ends cleanly downstream
            pay_beat.last = 1'b1;
            trunc_d       = 1'b1;
            state_d       = S_DROP;
            cnt_d         = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_DROP: begin
        if (in_acc && stream_in.LAST) state_d = S_HDR;
        else                          state_d = S_DROP;
      end
      default: begin
        state_d = S_HDR;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Control and sideband registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_HDR;
      cnt_q     <= 16'd0;
      hdr_q     <= '0;
      hdr_vld_q <= 1'b0;
      runt_q    <= 1'b0;
      trunc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hdr_q     <= hdr_d;
      hdr_vld_q <= hdr_vld_d;
      runt_q    <= runt_d;
      trunc_q   <= trunc_d;
    end
  end

  stream_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_beat   (pay_beat),
    .in_valid  (pay_vld),
    .in_ready  (skid_rdy),
    .out_beat  (out_beat),
    .out_valid (out_vld),
    .out_ready (stream_out.READY)
  );

  assign stream_out.DATA  = out_beat.data;
  assign stream_out.KEEP  = out_beat.keep;
  assign stream_out.LAST  = out_beat.last;
  assign stream_out.VALID = out_vld;
  assign hdr_DATA  = hdr_q;
  assign hdr_VALID = hdr_vld_q;
  assign err_runt  = runt_q;
  assign err_trunc = trunc_q;

`ifdef JSON_PKT_HDR_STRIP_STATS_EN
  logic [31:0] pkt_q, pkt_d, byte_q, byte_d;
  logic        out_xfer;

  assign out_xfer = out_vld & stream_out.READY;

  // Counters advance on downstream transfers only
  always_comb begin
    pkt_d  = pkt_q;
    byte_d = byte_q;
    if (out_xfer) begin
      byte_d = byte_q + {28'd0, popcount8(out_beat.keep)};
      pkt_d  = out_beat.last ? pkt_q + 32'd1 : pkt_q;
    end else begin
      byte_d = byte_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_q  <= 32'd0;
      byte_q <= 32'd0;
    end else begin
      pkt_q  <= pkt_d;
      byte_q <= byte_d;
    end
  end

  assign stat_pkt_cnt  = pkt_q;
  assign stat_byte_cnt = byte_q;
`endif

endmodule
